// File: rtl/scoreboard_register_file_pkg.sv
// Shared constants and types for the scoreboarded register file.
// Optional feature macro used by the top: REGFILE_BYPASS_EN.
package scoreboard_register_file_pkg;

  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int DEFAULT_ADDR_WIDTH = 5;

  typedef logic [DEFAULT_ADDR_WIDTH-1:0] reg_addr_t;

  // x0 is hardwired: it always reads zero and is never pending.
  localparam reg_addr_t ZERO_REG = '0;

endpackage

// File: rtl/scoreboard_register_file_regfile_scoreboard.sv
// Pending-bit scoreboard: reserve on issue, release on writeback, registered
// popcount of outstanding reservations and per-read-port pending lookups.
module regfile_scoreboard
  import scoreboard_register_file_pkg::*;
#(
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int NUM_READ   = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         release_en_i,
  input  logic [ADDR_WIDTH-1:0]        release_addr_i,
  input  logic                         reserve_en_i,
  input  logic [ADDR_WIDTH-1:0]        reserve_addr_i,
  input  logic [NUM_READ*ADDR_WIDTH-1:0] lookup_addr_i,
  output logic [NUM_READ-1:0]          lookup_pending_o,
  output logic [ADDR_WIDTH:0]          pending_count_o
);

  localparam int NUM_REGS = 2 ** ADDR_WIDTH;

  logic [NUM_REGS-1:0] pending_q;
  logic [NUM_REGS-1:0] pending_d;
  logic [ADDR_WIDTH:0] count_q;
  logic [ADDR_WIDTH:0] count_d;
  logic                release_hit;
  logic                reserve_hit;

  assign release_hit = release_en_i && (release_addr_i != ADDR_WIDTH'(ZERO_REG));
  assign reserve_hit = reserve_en_i && (reserve_addr_i != ADDR_WIDTH'(ZERO_REG));

  // Release is applied before reserve so a same-address pair leaves the bit set.
  always_comb begin
    pending_d = pending_q;
    if (release_hit) pending_d[release_addr_i] = 1'b0;
    if (reserve_hit) pending_d[reserve_addr_i] = 1'b1;
  end

  // Count is recomputed from the next-state vector, so it can never drift or wrap.
  always_comb begin
    count_d = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      count_d = count_d + (ADDR_WIDTH + 1)'(pending_d[i]);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending_q <= '0;
      count_q   <= '0;
    end else begin
      pending_q <= pending_d;
      count_q   <= count_d;
    end
  end

  always_comb begin
    lookup_pending_o = '0;
    for (int p = 0; p < NUM_READ; p++) begin
      lookup_pending_o[p] = pending_q[lookup_addr_i[p*ADDR_WIDTH +: ADDR_WIDTH]];
    end
  end

  assign pending_count_o = count_q;

endmodule

// File: rtl/scoreboard_register_file.sv
// Multi-read-port integer register file with per-register pending bits.
// Define REGFILE_BYPASS_EN to forward same-cycle writeback data to read ports.
module scoreboard_register_file
  import scoreboard_register_file_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int NUM_READ   = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_READ*ADDR_WIDTH-1:0] in_read_address,
  output logic [NUM_READ*DATA_WIDTH-1:0] out_read_data,
  output logic [NUM_READ-1:0]            out_read_pending,
  input  logic                           in_write_enable,
  input  logic [ADDR_WIDTH-1:0]          in_write_address,
  input  logic [DATA_WIDTH-1:0]          in_write_data,
  input  logic                           in_reserve_enable,
  input  logic [ADDR_WIDTH-1:0]          in_reserve_address,
  output logic [ADDR_WIDTH:0]            out_pending_count
);

  localparam int NUM_REGS = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [NUM_REGS];
  logic                  write_hit;
  logic [NUM_READ-1:0]   stored_pending;
  logic [ADDR_WIDTH-1:0] rd_addr;

  assign write_hit = in_write_enable && (in_write_address != ADDR_WIDTH'(ZERO_REG));

  regfile_scoreboard #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .NUM_READ   (NUM_READ)
  ) u_scoreboard (
    .clk              (clk),
    .reset            (reset),
    .release_en_i     (in_write_enable),
    .release_addr_i   (in_write_address),
    .reserve_en_i     (in_reserve_enable),
    .reserve_addr_i   (in_reserve_address),
    .lookup_addr_i    (in_read_address),
    .lookup_pending_o (stored_pending),
    .pending_count_o  (out_pending_count)
  );

  // x0 is never written, so its entry stays at its reset value of zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        mem_q[i] <= '0;
      end
    end else if (write_hit) begin
      mem_q[in_write_address] <= in_write_data;
    end
  end

  always_comb begin
    out_read_data    = '0;
    out_read_pending = '0;
    rd_addr          = '0;
    for (int p = 0; p < NUM_READ; p++) begin
      rd_addr = in_read_address[p*ADDR_WIDTH +: ADDR_WIDTH];
      out_read_data[p*DATA_WIDTH +: DATA_WIDTH] = mem_q[rd_addr];
      out_read_pending[p] = stored_pending[p];
`ifdef REGFILE_BYPASS_EN
      // Gated by reset so reads stay zero while the file is being cleared.
      if (write_hit && !reset && (rd_addr == in_write_address)) begin
        out_read_data[p*DATA_WIDTH +: DATA_WIDTH] = in_write_data;
        out_read_pending[p] = 1'b0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_scoreboard_register_file.sv
// Self-checking bench for scoreboard_register_file with four read ports.
module tb_scoreboard_register_file;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 4;
  localparam int NREGS = 32;

  logic             clk = 1'b0;
  logic             reset;
  logic [NR*AW-1:0] rd_addr;
  logic [NR*DW-1:0] rd_data;
  logic [NR-1:0]    rd_pend;
  logic             we;
  logic [AW-1:0]    wa;
  logic [DW-1:0]    wd;
  logic             re;
  logic [AW-1:0]    ra;
  logic [AW:0]      count;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] m_data [NREGS];
  bit            m_pend [NREGS];
  logic [DW-1:0] exp_q [$];

  always #5 clk = ~clk;

  scoreboard_register_file #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .NUM_READ   (NR)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .in_read_address    (rd_addr),
    .out_read_data      (rd_data),
    .out_read_pending   (rd_pend),
    .in_write_enable    (we),
    .in_write_address   (wa),
    .in_write_data      (wd),
    .in_reserve_enable  (re),
    .in_reserve_address (ra),
    .out_pending_count  (count)
  );

  // ---------------- reference model ----------------
  task automatic model_reset();
    for (int i = 0; i < NREGS; i++) begin
      m_data[i] = '0;
      m_pend[i] = 1'b0;
    end
  endtask

  task automatic model_commit();
    if (we && wa != 0) begin
      m_data[wa] = wd;
      m_pend[wa] = 1'b0;
    end
    if (re && ra != 0) m_pend[ra] = 1'b1;
  endtask

  function automatic logic [DW-1:0] exp_data(input int a);
`ifdef REGFILE_BYPASS_EN
    if (we && wa != 0 && int'(wa) == a) return wd;
`endif
    return m_data[a];
  endfunction

  function automatic bit exp_pend(input int a);
`ifdef REGFILE_BYPASS_EN
    if (we && wa != 0 && int'(wa) == a) return 1'b0;
`endif
    return m_pend[a];
  endfunction

  function automatic int exp_count();
    int n = 0;
    for (int i = 0; i < NREGS; i++) if (m_pend[i]) n++;
    return n;
  endfunction

  // ---------------- drivers ----------------
  task automatic clock_edge();
    @(posedge clk);
    model_commit();
    #1;
  endtask

  task automatic idle();
    we = 1'b0; wa = '0; wd = '0;
    re = 1'b0; ra = '0;
  endtask

  task automatic set_reads(input logic [AW-1:0] a0, a1, a2, a3);
    rd_addr = {a3, a2, a1, a0};
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    idle();
    reset = 1'b1;
    model_reset();
    set_reads(5'd0, 5'd1, 5'd31, 5'd0);
    #1;
    for (int p = 0; p < NR; p++) begin
      checks++;
      if (rd_data[p*DW +: DW] !== '0) begin
        errors++;
        $display("FAIL reset_data port%0d: got %h expected 0", p, rd_data[p*DW +: DW]);
      end
    end
    checks++;
    if (rd_pend !== '0) begin
      errors++;
      $display("FAIL reset_pend: got %b expected 0000", rd_pend);
    end
    checks++;
    if (count !== '0) begin
      errors++;
      $display("FAIL reset_count: got %0d expected 0", count);
    end
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_zero_reg();
    we = 1'b1; wa = 5'd0; wd = 32'd10;
    re = 1'b1; ra = 5'd0;
    clock_edge();
    idle();
    set_reads(5'd0, 5'd0, 5'd0, 5'd0);
    #1;
    checks++;
    if (rd_data[0 +: DW] !== 32'd0 || rd_pend[0] !== 1'b0 || count !== '0) begin
      errors++;
      $display("FAIL zero_reg: got data %h pend %b count %0d expected 0 0 0",
               rd_data[0 +: DW], rd_pend[0], count);
    end
  endtask

  task automatic test_write_latency();
    logic [DW-1:0] same_cycle;
    we = 1'b1; wa = 5'd1; wd = 32'd20;
    set_reads(5'd1, 5'd0, 5'd0, 5'd0);
    #1;
`ifdef REGFILE_BYPASS_EN
    same_cycle = 32'd20;
`else
    same_cycle = 32'd0;
`endif
    checks++;
    if (rd_data[0 +: DW] !== same_cycle) begin
      errors++;
      $display("FAIL write_same_cycle: got %0d expected %0d", rd_data[0 +: DW], same_cycle);
    end
    clock_edge();
    idle();
    #1;
    checks++;
    if (rd_data[0 +: DW] !== 32'd20) begin
      errors++;
      $display("FAIL write_next_cycle: got %0d expected 20", rd_data[0 +: DW]);
    end
  endtask

  task automatic test_reserve();
    bit wb_pend;
    re = 1'b1; ra = 5'd5;
    set_reads(5'd0, 5'd5, 5'd0, 5'd0);
    #1;
    checks++;
    if (rd_pend[1] !== 1'b0) begin
      errors++;
      $display("FAIL reserve_latency: got pend %b expected 0", rd_pend[1]);
    end
    clock_edge();
    checks++;
    if (rd_pend[1] !== 1'b1 || count !== 6'd1) begin
      errors++;
      $display("FAIL reserve_x5: got pend %b count %0d expected 1 1", rd_pend[1], count);
    end
    clock_edge();
    idle();
    #1;
    checks++;
    if (rd_pend[1] !== 1'b1 || count !== 6'd1) begin
      errors++;
      $display("FAIL reserve_twice: got pend %b count %0d expected 1 1", rd_pend[1], count);
    end
    we = 1'b1; wa = 5'd5; wd = 32'd30;
    #1;
`ifdef REGFILE_BYPASS_EN
    wb_pend = 1'b0;
`else
    wb_pend = 1'b1;
`endif
    checks++;
    if (rd_pend[1] !== wb_pend) begin
      errors++;
      $display("FAIL writeback_same_cycle_pend: got %b expected %b", rd_pend[1], wb_pend);
    end
    clock_edge();
    idle();
    #1;
    checks++;
    if (rd_data[DW +: DW] !== 32'd30 || rd_pend[1] !== 1'b0 || count !== 6'd0) begin
      errors++;
      $display("FAIL writeback_x5: got data %0d pend %b count %0d expected 30 0 0",
               rd_data[DW +: DW], rd_pend[1], count);
    end
  endtask

  task automatic test_same_cycle_write_reserve();
    logic [DW-1:0] fwd;
    we = 1'b1; wa = 5'd7; wd = 32'd40;
    re = 1'b1; ra = 5'd7;
    set_reads(5'd0, 5'd0, 5'd7, 5'd0);
    #1;
`ifdef REGFILE_BYPASS_EN
    fwd = 32'd40;
`else
    fwd = 32'd0;
`endif
    checks++;
    if (rd_data[2*DW +: DW] !== fwd || rd_pend[2] !== 1'b0) begin
      errors++;
      $display("FAIL wr_rsv_same_cycle: got data %0d pend %b expected %0d 0",
               rd_data[2*DW +: DW], rd_pend[2], fwd);
    end
    clock_edge();
    idle();
    #1;
    checks++;
    if (rd_data[2*DW +: DW] !== 32'd40 || rd_pend[2] !== 1'b1 || count !== 6'd1) begin
      errors++;
      $display("FAIL wr_rsv_x7: got data %0d pend %b count %0d expected 40 1 1",
               rd_data[2*DW +: DW], rd_pend[2], count);
    end
  endtask

  task automatic test_async_reset();
    re = 1'b1; ra = 5'd3; clock_edge();
    ra = 5'd4;            clock_edge();
    ra = 5'd6;            clock_edge();
    idle();
    set_reads(5'd3, 5'd4, 5'd6, 5'd7);
    #1;
    checks++;
    if (count !== 6'd4 || rd_pend !== 4'b1111) begin
      errors++;
      $display("FAIL pre_reset: got count %0d pend %b expected 4 1111", count, rd_pend);
    end
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (count !== '0 || rd_pend !== '0) begin
      errors++;
      $display("FAIL async_reset_pend: got count %0d pend %b expected 0 0000", count, rd_pend);
    end
    checks++;
    if (rd_data[3*DW +: DW] !== '0) begin
      errors++;
      $display("FAIL async_reset_data: got %h expected 0", rd_data[3*DW +: DW]);
    end
    model_reset();
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_all_ports();
    we = 1'b1; wa = 5'd2; wd = 32'hDEADBEEF;
    clock_edge();
    idle();
    set_reads(5'd2, 5'd2, 5'd2, 5'd2);
    #1;
    for (int p = 0; p < NR; p++) begin
      checks++;
      if (rd_data[p*DW +: DW] !== 32'hDEADBEEF) begin
        errors++;
        $display("FAIL all_ports port%0d: got %h expected deadbeef", p, rd_data[p*DW +: DW]);
      end
    end
  endtask

  task automatic test_random();
    logic [AW-1:0] a [NR];
    logic [DW-1:0] e;
    for (int it = 0; it < 400; it++) begin
      we = ($urandom_range(0, 99) < 45);
      wa = AW'($urandom_range(0, 3) == 0 ? $urandom_range(0, 31) : $urandom_range(0, 7));
      wd = $urandom;
      re = ($urandom_range(0, 99) < 50);
      ra = AW'($urandom_range(0, 3) == 0 ? $urandom_range(0, 31) : $urandom_range(0, 7));
      for (int p = 0; p < NR; p++) begin
        a[p] = ($urandom_range(0, 2) == 0) ? wa : AW'($urandom_range(0, 7));
      end
      set_reads(a[0], a[1], a[2], a[3]);
      #1;
      for (int p = 0; p < NR; p++) exp_q.push_back(exp_data(int'(a[p])));
      for (int p = 0; p < NR; p++) begin
        e = exp_q.pop_front();
        checks++;
        if (rd_data[p*DW +: DW] !== e || rd_pend[p] !== exp_pend(int'(a[p]))) begin
          errors++;
          $display("FAIL rand_read it%0d port%0d addr %0d: got %h/%b expected %h/%b",
                   it, p, a[p], rd_data[p*DW +: DW], rd_pend[p], e, exp_pend(int'(a[p])));
        end
      end
      checks++;
      if (int'(count) !== exp_count()) begin
        errors++;
        $display("FAIL rand_count it%0d: got %0d expected %0d", it, count, exp_count());
      end
      clock_edge();
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_zero_reg();
    test_write_latency();
    test_reserve();
    test_same_cycle_write_reserve();
    test_async_reset();
    test_all_ports();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
